// File: rtl/grf_wr_arbiter.sv
// GRF write-port arbiter: pipeline writeback has priority, aux writes are queued, aged and WAW-squashed.
// Define GRF_ARB_TRACE_EN to print every issued write and squashed entry; the logic is unchanged.
module grf_wr_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic [31:0] pipe_pc,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_addr,
    input  logic [31:0] aux_data,
    input  logic [31:0] aux_pc,
    output logic        grf_we,
    output logic [4:0]  grf_addr,
    output logic [31:0] grf_wdata,
    output logic [31:0] grf_pc,
    output logic [31:0] pend_mask,
    output logic        stall_req
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } entryT;

    entryT             qEntry [DEPTH];
    logic [DEPTH-1:0]  qValid;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  count;
    logic [AGE_W-1:0]  age;

    logic pipeLive;
    logic full;
    logic headPresent;
    logic headValid;
    logic headSquash;
    logic doPop;
    logic doEnq;
    entryT headEntry;

    // Issue/queue decisions are taken from registered state plus this cycle's requests.
    always_comb begin
        pipeLive    = pipe_we && (pipe_addr != 5'd0);
        full        = (count == CNT_W'(DEPTH));
        headPresent = (count != '0);
        headEntry   = qEntry[rdPtr];
        headValid   = headPresent && qValid[rdPtr];
        headSquash  = pipeLive && headValid && (headEntry.addr == pipe_addr);
        doPop       = !pipeLive && headPresent;
        doEnq       = aux_valid && !full && (aux_addr != 5'd0);
    end

    assign aux_ready = !full;
    assign stall_req = (age == AGE_W'(STARVE_LIMIT));

    // Hazard mask: one bit per register with a live queued write.
    always_comb begin
        pend_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (qValid[i]) begin
                pend_mask[qEntry[i].addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            age       <= '0;
            qValid    <= '0;
            grf_we    <= 1'b0;
            grf_addr  <= '0;
            grf_wdata <= '0;
            grf_pc    <= '0;
        end else begin
            // A newer pipe write kills older queued writes to the same register.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (pipeLive && (qEntry[i].addr == pipe_addr)) begin
                    qValid[i] <= 1'b0;
                end
            end

            if (doPop) begin
                qValid[rdPtr] <= 1'b0;
                rdPtr         <= rdPtr + PTR_W'(1);
            end

            // Enqueue after the squash loop so a same-edge aux entry survives.
            if (doEnq) begin
                qValid[wrPtr] <= 1'b1;
                qEntry[wrPtr] <= '{addr: aux_addr, data: aux_data, pc: aux_pc};
                wrPtr         <= wrPtr + PTR_W'(1);
            end

            case ({doEnq, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (doPop || !headValid || headSquash) begin
                age <= '0;
            end else if (!stall_req) begin
                age <= age + AGE_W'(1);
            end

            if (pipeLive) begin
                grf_we    <= 1'b1;
                grf_addr  <= pipe_addr;
                grf_wdata <= pipe_data;
                grf_pc    <= pipe_pc;
            end else if (doPop && headValid) begin
                grf_we    <= 1'b1;
                grf_addr  <= headEntry.addr;
                grf_wdata <= headEntry.data;
                grf_pc    <= headEntry.pc;
            end else begin
                grf_we    <= 1'b0;
            end
        end
    end

`ifdef GRF_ARB_TRACE_EN
    always @(posedge clk) begin
        if (reset) begin
            if (pipeLive) begin
                $display("@%h: $%d <= %h", pipe_pc, pipe_addr, pipe_data);
            end else if (doPop && headValid) begin
                $display("@%h: $%d <= %h", headEntry.pc, headEntry.addr, headEntry.data);
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (pipeLive && qValid[i] && (qEntry[i].addr == pipe_addr)) begin
                    $display("SQUASH $%d", qEntry[i].addr);
                end
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_grf_wr_arbiter.sv
// Scoreboard bench for grf_wr_arbiter: a queue-level model predicts every cycle's outputs.
module tb_grf_wr_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic [31:0] pipe_pc;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_addr;
    logic [31:0] aux_data;
    logic [31:0] aux_pc;
    logic        grf_we;
    logic [4:0]  grf_addr;
    logic [31:0] grf_wdata;
    logic [31:0] grf_pc;
    logic [31:0] pend_mask;
    logic        stall_req;

    grf_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_pc(pipe_pc),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr),
        .aux_data(aux_data), .aux_pc(aux_pc),
        .grf_we(grf_we), .grf_addr(grf_addr), .grf_wdata(grf_wdata), .grf_pc(grf_pc),
        .pend_mask(pend_mask), .stall_req(stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] pc;
        bit          v;
    } mEntT;

    typedef struct {
        bit          full;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
        logic        ready;
        logic [31:0] mask;
        logic        stall;
    } expT;

    mEntT mq[$];
    expT  sb[$];
    int   mage = 0;
    int   checks = 0;
    int   failures = 0;
    int   wr9Good = 0;
    int   wr9Bad = 0;
    bit   stallSeen = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle, predict its outcome, then compare after the edge.
    task automatic step(input logic rst, input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                        input logic av, input logic [4:0] aa, input logic [31:0] ad);
        expT  e;
        mEntT n;
        bit   rdy;
        bit   live;
        reset     = rst;
        pipe_we   = pw;
        pipe_addr = pa;
        pipe_data = pd;
        pipe_pc   = 32'h0040_0000 + pd;
        aux_valid = av;
        aux_addr  = aa;
        aux_data  = ad;
        aux_pc    = 32'h0080_0000 + ad;

        e.full = !rst;
        e.we = 1'b0; e.addr = '0; e.data = '0; e.pc = '0;
        if (!rst) begin
            mq.delete();
            mage = 0;
        end else begin
            rdy  = mq.size() < DEPTH;
            live = pw && (pa != 5'd0);
            if (live) begin
                e.we = 1'b1; e.addr = pa; e.data = pd; e.pc = pipe_pc;
                if (mq.size() > 0 && mq[0].v)
                    mage = (mq[0].a == pa) ? 0 : ((mage < LIMIT) ? mage + 1 : LIMIT);
                else
                    mage = 0;
                foreach (mq[i]) if (mq[i].a == pa) mq[i].v = 0;
            end else if (mq.size() > 0) begin
                n = mq.pop_front();
                if (n.v) begin
                    e.we = 1'b1; e.addr = n.a; e.data = n.d; e.pc = n.pc;
                end
                mage = 0;
            end else begin
                mage = 0;
            end
            if (av && rdy && aa != 5'd0) begin
                n.a = aa; n.d = ad; n.pc = aux_pc; n.v = 1;
                mq.push_back(n);
            end
        end
        e.ready = mq.size() < DEPTH;
        e.mask  = '0;
        foreach (mq[i]) if (mq[i].v) e.mask[mq[i].a] = 1'b1;
        e.stall = (mage == LIMIT);
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkEq("grf_we", 32'(grf_we), 32'(e.we));
        if (e.we || e.full) begin
            checkEq("grf_addr", 32'(grf_addr), 32'(e.addr));
            checkEq("grf_wdata", grf_wdata, e.data);
            checkEq("grf_pc", grf_pc, e.pc);
        end
        checkEq("aux_ready", 32'(aux_ready), 32'(e.ready));
        checkEq("pend_mask", pend_mask, e.mask);
        checkEq("stall_req", 32'(stall_req), 32'(e.stall));
        if (stall_req) stallSeen = 1;
        if (grf_we && grf_addr == 5'd9) begin
            if (grf_wdata == 32'h55) wr9Good++;
            else wr9Bad++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // reset
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        checkEq("reset_ready", 32'(aux_ready), 32'd1);

        // pipe write, latency 1
        step(1, 1, 5, 32'h1234, 0, 0, 0);
        idle(1);

        // single aux write, latency 2
        step(1, 0, 0, 0, 1, 8, 32'hAA);
        idle(3);

        // fill queue under constant pipe traffic, starve, then drain
        for (int k = 0; k < 4; k++) step(1, 1, 3, 32'h300 + k, 1, 5'(10 + k), 32'hB0 + k);
        step(1, 1, 3, 32'h304, 1, 20, 32'hBF);
        for (int k = 0; k < 10; k++) step(1, 1, 3, 32'h310 + k, 0, 0, 0);
        checkEq("stall_seen", 32'(stallSeen), 32'd1);
        step(1, 1, 3, 32'h320, 0, 0, 0);
        idle(6);

        // WAW squash of an older entry
        step(1, 1, 3, 32'h400, 1, 9, 32'h77);
        step(1, 1, 9, 32'h55, 0, 0, 0);
        idle(3);
        checkEq("wr9_good", 32'(wr9Good), 32'd1);
        checkEq("wr9_bad", 32'(wr9Bad), 32'd0);

        // same-edge enqueue survives, aux to $0 discarded
        step(1, 1, 7, 32'h70, 1, 7, 32'h71);
        step(1, 0, 0, 0, 1, 0, 32'hDEAD);
        idle(3);

        // reset with queued entries
        for (int k = 0; k < 3; k++) step(1, 1, 2, 32'h600 + k, 1, 5'(14 + k), 32'hC0 + k);
        step(0, 0, 0, 0, 0, 0, 0);
        idle(4);

        // random traffic over a small register range to provoke squashes
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 63) != 0),
                 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
